// File: rtl/grid_cfg_loader.sv
// Loads the 8x8 rotating-tile grid: buffers one plane per chain length, scans it in, latches V/H/D,
// loads flop state, then runs the loop-breaker class rotation. Optional readback: GRID_CFG_READBACK_EN.
module grid_cfg_loader #(
  parameter int CHAIN_LEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       scan_se,
  output logic       scan_sc,
  input  logic       scan_ret,
  output logic [1:0] cfg_sel,
  output logic       lb_en,
  output logic [1:0] lb_class,
  output logic       busy,
  output logic       done,
  output logic [7:0] rb_data,
  output logic       rb_valid
);

  localparam int BYTES = CHAIN_LEN / 8;
  localparam int BCW   = $clog2(BYTES + 1);
  localparam int SCW   = $clog2(CHAIN_LEN);
  localparam logic [BCW-1:0] BYTES_C   = BCW'(BYTES);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [SCW-1:0] LAST_BIT  = SCW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SHIFT,
    S_LATCH,
    S_RUN
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           plane;
  logic [BCW-1:0]       byte_cnt;
  logic [SCW-1:0]       bit_cnt;
  logic [CHAIN_LEN-1:0] buffer;
  logic                 xfer;
  logic                 last_bit;

  assign xfer     = s_valid && s_ready;
  assign last_bit = (bit_cnt == LAST_BIT);

  // The loop breaker stays engaged throughout loading and run; only the class rotates.
  assign lb_en   = 1'b1;
  assign scan_sc = scan_se & buffer[0];

  // NOTE: every output of this block gets a default first, so no path can infer a latch
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    scan_se = 1'b0;
    cfg_sel = 2'd0;
    busy    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FILL;
      end
      S_FILL: begin
        busy    = 1'b1;
        s_ready = (byte_cnt < BYTES_C);
        if (s_valid && (byte_cnt == LAST_BYTE)) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy    = 1'b1;
        scan_se = 1'b1;
        if (last_bit) state_d = (plane == 2'd3) ? S_RUN : S_LATCH;
      end
      S_LATCH: begin
        busy    = 1'b1;
        cfg_sel = plane + 2'd1;
        state_d = S_FILL;
      end
      S_RUN: begin
        if (start)     state_d = S_FILL;
        else if (stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      plane    <= 2'd0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      lb_class <= 2'd0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == S_SHIFT) && (state_d == S_RUN);

      if (state_q != S_FILL) byte_cnt <= '0;
      else if (xfer)         byte_cnt <= byte_cnt + 1'b1;

      bit_cnt <= ((state_q == S_SHIFT) && !last_bit) ? bit_cnt + 1'b1 : '0;

      if (state_q == S_LATCH) plane <= plane + 2'd1;
      else if (((state_q == S_IDLE) || (state_q == S_RUN)) && start) plane <= 2'd0;

      if ((state_q == S_SHIFT) && (state_d == S_RUN)) lb_class <= 2'd0;
      else if ((state_q == S_RUN) && (state_d == S_RUN)) lb_class <= lb_class + 2'd1;
    end
  end

  // NOTE: the plane buffer is pure datapath, always fully refilled before use, so it takes no reset
  always_ff @(posedge clk) begin
    if (xfer)                    buffer <= {s_data, buffer[CHAIN_LEN-1:8]};
    else if (state_q == S_SHIFT) buffer <= {1'b0, buffer[CHAIN_LEN-1:1]};
  end

`ifdef GRID_CFG_READBACK_EN
  logic [7:0] rb_shift;
  logic       capture;

  // The plane-3 shift pushes the previous chain contents out of scan_ret, LSB of each byte first.
  assign capture = (state_q == S_SHIFT) && (plane == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_shift <= 8'd0;
      rb_data  <= 8'd0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (capture) begin
        rb_shift <= {scan_ret, rb_shift[7:1]};
        if (bit_cnt[2:0] == 3'd7) begin
          rb_data  <= {scan_ret, rb_shift[7:1]};
          rb_valid <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_ret;
  assign unused_ret = scan_ret;
  assign rb_data    = 8'd0;
  assign rb_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_grid_cfg_loader.sv
// Directed bench for grid_cfg_loader with a behavioural scan-chain model of the grid and a
// byte scoreboard on scan_sc; readback expectations follow GRID_CFG_READBACK_EN.
module tb_grid_cfg_loader;

  localparam int CHAIN_LEN = 64;
  localparam int BYTES     = CHAIN_LEN / 8;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       scan_se;
  logic       scan_sc;
  logic       scan_ret;
  logic [1:0] cfg_sel;
  logic       lb_en;
  logic [1:0] lb_class;
  logic       busy;
  logic       done;
  logic [7:0] rb_data;
  logic       rb_valid;

  grid_cfg_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .scan_se  (scan_se),
    .scan_sc  (scan_sc),
    .scan_ret (scan_ret),
    .cfg_sel  (cfg_sel),
    .lb_en    (lb_en),
    .lb_class (lb_class),
    .busy     (busy),
    .done     (done),
    .rb_data  (rb_data),
    .rb_valid (rb_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grid scan chain: bit 0 is the first tile, bit CHAIN_LEN-1 the last tile (y7,x7).
  logic [CHAIN_LEN-1:0] chain = '0;
  always @(posedge clk) if (scan_se === 1'b1) chain <= {chain[CHAIN_LEN-2:0], scan_sc};
  assign scan_ret = chain[CHAIN_LEN-1];

  int         total = 0;
  int         bad   = 0;
  int         cnt   = 0;
  int         rb_seen = 0;
  logic [7:0] pd [4][BYTES];
  logic [7:0] sb_q[$];
`ifdef GRID_CFG_READBACK_EN
  logic [7:0] rb_q[$];
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cnt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cnt++;
    if (rb_valid === 1'b1) begin
      rb_seen++;
`ifdef GRID_CFG_READBACK_EN
      if (rb_q.size() != 0) check("rb_data", rb_data, rb_q.pop_front());
      else check("rb_unexpected", rb_q.size(), 1);
`endif
    end
  endtask

  // Full four-plane load from pd[][]; optional s_valid gap after byte gap_byte of gap_plane.
  task automatic do_load(input bit with_stop, input int gap_plane, input int gap_byte,
                         input int gap_len);
    int         se_cnt;
    logic [7:0] obs;
    rb_seen = 0;
    obs     = 8'd0;
    start   = 1'b1;
    stop    = with_stop;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("fill_busy", busy, 1);
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < BYTES; b++) begin
        s_data  = pd[p][b];
        s_valid = 1'b1;
        check("fill_ready", s_ready, 1);
        sb_q.push_back(pd[p][b]);
`ifdef GRID_CFG_READBACK_EN
        if (p == 2) rb_q.push_back(pd[p][b]);
`endif
        step();
        if (p == gap_plane && b == gap_byte) begin
          s_valid = 1'b0;
          s_data  = 8'hEE;
          for (int g = 0; g < gap_len; g++) begin
            check("gap_ready", s_ready, 1);
            check("gap_se", scan_se, 0);
            step();
          end
        end
      end
      // A byte offered while not ready must not be consumed.
      s_valid = 1'b1;
      s_data  = 8'hFF;
      check("shift_ready", s_ready, 0);
      se_cnt = 0;
      for (int k = 0; k < CHAIN_LEN; k++) begin
        if (scan_se === 1'b1) se_cnt++;
        obs[k % 8] = scan_sc;
        if (k % 8 == 7) begin
          if (sb_q.size() != 0) check("scan_byte", obs, sb_q.pop_front());
          else check("scan_sb_empty", sb_q.size(), 1);
        end
        if (k == CHAIN_LEN - 1) check("shift_done_low", done, 0);
        step();
      end
      s_valid = 1'b0;
      check("shift_len", se_cnt, CHAIN_LEN);
      if (p < 3) begin
        check("latch_sel", cfg_sel, p + 1);
        check("latch_se", scan_se, 0);
        check("latch_busy", busy, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("post_latch_sel", cfg_sel, 0);
      end else begin
        check("done_pulse", done, 1);
        check("run_lb0", lb_class, 0);
        check("run_busy", busy, 0);
        check("run_se", scan_se, 0);
      end
    end
`ifdef GRID_CFG_READBACK_EN
    check("rb_count", rb_seen, BYTES);
`else
    check("rb_none", rb_seen, 0);
`endif
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'd0;
    step();
    step();
    check("rst_se", scan_se, 0);
    check("rst_sc", scan_sc, 0);
    check("rst_cfg", cfg_sel, 0);
    check("rst_lb_en", lb_en, 1);
    check("rst_lbc", lb_class, 0);
    check("rst_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rbv", rb_valid, 0);
    check("rst_rbd", rb_data, 0);
    rst = 1'b0;
    step();
    check("idle_busy", busy, 0);

    // Abandon a load with reset at cycle 40 (mid plane-0 SHIFT).
    start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < BYTES; b++) begin
      s_valid = 1'b1;
      s_data  = 8'(b);
      step();
    end
    s_valid = 1'b0;
    repeat (31) step();
    check("pre_rst_se", scan_se, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_se", scan_se, 0);
    check("mid_rst_cfg", cfg_sel, 0);
    check("mid_rst_lb_en", lb_en, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", s_ready, 0);
    step();
    rst = 1'b0;
    step();
    sb_q.delete();
`ifdef GRID_CFG_READBACK_EN
    rb_q.delete();
`endif

    // Full load of 0xA5 everywhere, s_valid always high.
    for (int p = 0; p < 4; p++) for (int b = 0; b < BYTES; b++) pd[p][b] = 8'hA5;
    do_load(1'b0, -1, -1, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("lb_rotate", lb_class, i % 4);
      check("done_once", done, 0);
    end

    // Reload from RUN with start and stop together; 20-cycle gap after byte 3 of plane 1.
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < BYTES; b++) pd[p][b] = 8'((p + 1) * 16 + b * 3 + 1);
    for (int b = 0; b < BYTES; b++) pd[3][b] = (b == 0) ? 8'h01 : 8'h00;
    do_load(1'b1, 1, 3, 20);
    check("flop_state", chain, 64'h8000_0000_0000_0000);

    // stop leaves RUN with lb_class frozen.
    step();
    check("run_lb1", lb_class, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_ready", s_ready, 0);
    check("stop_lbc", lb_class, 1);
    repeat (3) step();
    check("idle_lbc_frozen", lb_class, 1);
    check("idle_busy2", busy, 0);

    // Reload with 0x3C everywhere; readback carries out the previous chain contents.
    for (int p = 0; p < 4; p++) for (int b = 0; b < BYTES; b++) pd[p][b] = 8'h3C;
    do_load(1'b0, -1, -1, 0);
`ifndef GRID_CFG_READBACK_EN
    check("rb_data_zero", rb_data, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
